// File: rtl/noise_gate_if.sv
// Sample stream bundle for the noise gate: enable, input strobe/sample, gated output and LED.
// The master drives the input side; the slave (the gate) drives the output side.
interface noise_gate_if #(
   parameter int unsigned DATA_WIDTH = 24
);
   logic                         en_i;
   logic signed [DATA_WIDTH-1:0] sample_i;
   logic                         sample_valid_i;
   logic signed [DATA_WIDTH-1:0] sample_o;
   logic                         sample_valid_o;
   logic                         gate_open_o;

   modport master (
      output en_i,
      output sample_i,
      output sample_valid_i,
      input  sample_o,
      input  sample_valid_o,
      input  gate_open_o
   );

   modport slave (
      input  en_i,
      input  sample_i,
      input  sample_valid_i,
      output sample_o,
      output sample_valid_o,
      output gate_open_o
   );
endinterface

// File: rtl/noise_gate.sv
// Peak-envelope noise gate with hysteresis, hold and click-free attack/release gain ramps.
// Gated samples appear two cycles after their input strobe.
module noise_gate #(
   parameter int unsigned DATA_WIDTH   = 24,
   parameter int unsigned THRESHOLD    = 300,
   parameter int unsigned HYST         = 64,
   parameter int unsigned HOLD_SAMPLES = 2400,
   parameter int unsigned DECAY_SHIFT  = 4,
   parameter int unsigned GAIN_W       = 8,
   parameter int unsigned ATTACK_STEP  = 64,
   parameter int unsigned RELEASE_STEP = 16
) (
   input logic         clk_i,
   input logic         rst_i,
   noise_gate_if.slave gate_io
);

   localparam int unsigned HoldW = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
   localparam int unsigned ProdW = DATA_WIDTH + GAIN_W + 2;
   localparam logic [GAIN_W:0]         Unity    = {1'b1, {GAIN_W{1'b0}}};
   localparam logic [GAIN_W+1:0]       AttackW  = (GAIN_W + 2)'(ATTACK_STEP);
   localparam logic [GAIN_W:0]         ReleaseW = (GAIN_W + 1)'(RELEASE_STEP);
   localparam logic [DATA_WIDTH-1:0]   OpenLvl  = DATA_WIDTH'(THRESHOLD);
   localparam logic [DATA_WIDTH-1:0]   CloseLvl = DATA_WIDTH'(THRESHOLD - HYST);
   localparam logic [DATA_WIDTH-1:0]   MaxPos   = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0]   MostNeg  = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

   typedef enum logic [2:0] {StClosed, StAttack, StOpen, StHold, StRelease} state_e;

   state_e                       state_q, state_d;
   logic [DATA_WIDTH-1:0]        env_q, env_d;
   logic [GAIN_W:0]              gain_q, gain_d;
   logic [HoldW-1:0]             hold_q, hold_d;
   logic signed [DATA_WIDTH-1:0] s1_sample_q, s1_sample_d;
   logic [GAIN_W:0]              s1_gain_q, s1_gain_d;
   logic                         s1_valid_q, s1_valid_d;
   logic signed [DATA_WIDTH-1:0] out_sample_q, out_sample_d;
   logic                         out_valid_q, out_valid_d;
   logic                         open_q, open_d;

   logic [DATA_WIDTH-1:0] abs_mag, env_dec, env_next;
   logic [GAIN_W+1:0]     gain_up_w;
   logic [GAIN_W:0]       gain_up, gain_dn;
   logic [ProdW-1:0]      prod;
   logic                  unused_prod;

   always_comb begin
      abs_mag = gate_io.sample_i;
      if (gate_io.sample_i[DATA_WIDTH-1]) begin
         // The most negative value has no positive twin; clamp it.
         abs_mag = (gate_io.sample_i == MostNeg) ? MaxPos : -gate_io.sample_i;
      end
      env_dec   = env_q - (env_q >> DECAY_SHIFT);
      env_next  = (abs_mag > env_dec) ? abs_mag : env_dec;
      gain_up_w = {1'b0, gain_q} + AttackW;
      gain_up   = (gain_up_w >= {1'b0, Unity}) ? Unity : gain_up_w[GAIN_W:0];
      gain_dn   = (gain_q > ReleaseW) ? gain_q - ReleaseW : '0;
   end

   // The gain moves on the same sample that enters ATTACK or RELEASE.
   always_comb begin
      state_d = state_q;
      gain_d  = gain_q;
      hold_d  = hold_q;
      env_d   = env_q;
      if (gate_io.sample_valid_i) begin
         env_d = env_next;
         if (!gate_io.en_i) begin
            state_d = StOpen;
            gain_d  = Unity;
            hold_d  = '0;
         end else begin
            unique case (state_q)
               StClosed: begin
                  if (env_next >= OpenLvl) begin
                     gain_d  = gain_up;
                     state_d = (gain_up == Unity) ? StOpen : StAttack;
                  end
               end
               StAttack: begin
                  if (env_next < CloseLvl) begin
                     gain_d  = gain_dn;
                     state_d = (gain_dn == '0) ? StClosed : StRelease;
                  end else begin
                     gain_d  = gain_up;
                     state_d = (gain_up == Unity) ? StOpen : StAttack;
                  end
               end
               StOpen: begin
                  gain_d = Unity;
                  if (env_next < CloseLvl) begin
                     if (HOLD_SAMPLES == 0) begin
                        gain_d  = gain_dn;
                        state_d = StRelease;
                     end else begin
                        hold_d  = HoldW'(HOLD_SAMPLES - 1);
                        state_d = StHold;
                     end
                  end
               end
               StHold: begin
                  gain_d = Unity;
                  if (env_next >= OpenLvl) begin
                     state_d = StOpen;
                  end else if (hold_q == '0) begin
                     gain_d  = gain_dn;
                     state_d = StRelease;
                  end else begin
                     hold_d = hold_q - 1'b1;
                  end
               end
               StRelease: begin
                  if (env_next >= OpenLvl) begin
                     gain_d  = gain_up;
                     state_d = (gain_up == Unity) ? StOpen : StAttack;
                  end else begin
                     gain_d  = gain_dn;
                     state_d = (gain_dn == '0) ? StClosed : StRelease;
                  end
               end
               default: state_d = StClosed;
            endcase
         end
      end
   end

   // Stage 1 captures the gain in effect before this sample's update; stage 2 scales.
   always_comb begin
      s1_valid_d  = gate_io.sample_valid_i;
      s1_sample_d = gate_io.sample_valid_i ? gate_io.sample_i : s1_sample_q;
      s1_gain_d   = s1_gain_q;
      if (gate_io.sample_valid_i) begin
         s1_gain_d = gate_io.en_i ? gain_q : Unity;
      end
      prod         = ProdW'(s1_sample_q) * ProdW'(s1_gain_q);
      out_valid_d  = s1_valid_q;
      out_sample_d = s1_valid_q ? prod[GAIN_W +: DATA_WIDTH] : out_sample_q;
      open_d       = (state_q != StClosed);
   end

   assign unused_prod = ^{prod[GAIN_W-1:0], prod[ProdW-1:GAIN_W+DATA_WIDTH]};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StClosed;
         env_q        <= '0;
         gain_q       <= '0;
         hold_q       <= '0;
         s1_sample_q  <= '0;
         s1_gain_q    <= '0;
         s1_valid_q   <= 1'b0;
         out_sample_q <= '0;
         out_valid_q  <= 1'b0;
         open_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         env_q        <= env_d;
         gain_q       <= gain_d;
         hold_q       <= hold_d;
         s1_sample_q  <= s1_sample_d;
         s1_gain_q    <= s1_gain_d;
         s1_valid_q   <= s1_valid_d;
         out_sample_q <= out_sample_d;
         out_valid_q  <= out_valid_d;
         open_q       <= open_d;
      end
   end

   assign gate_io.sample_o       = out_sample_q;
   assign gate_io.sample_valid_o = out_valid_q;
   assign gate_io.gate_open_o    = open_q;

endmodule

// File: tb/tb_noise_gate.sv
// Directed vector bench for noise_gate: a scoreboard checks every output strobe for value,
// gate LED and exact two-cycle latency; reset and bypass corners are driven by hand.
module tb_noise_gate;
   localparam int DW = 24;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   noise_gate_if #(.DATA_WIDTH(DW)) ng_if ();

   noise_gate #(
      .DATA_WIDTH  (DW),
      .THRESHOLD   (300),
      .HYST        (64),
      .HOLD_SAMPLES(4),
      .DECAY_SHIFT (4),
      .GAIN_W      (8),
      .ATTACK_STEP (64),
      .RELEASE_STEP(16)
   ) u_dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .gate_io(ng_if.slave)
   );

   typedef struct {
      logic en;
      int   s;
      int   gap;
      int   exp_s;
      logic exp_open;
   } vec_t;

   vec_t       vecs[$];
   vec_t       exp_q[$];
   int         n_tests;
   int         n_fail;
   logic       chk_en;
   logic [1:0] hist;
   int         idx_g;

   function automatic void add(logic en, int s, int gap, int e, logic o);
      vec_t v;
      v.en = en; v.s = s; v.gap = gap; v.exp_s = e; v.exp_open = o;
      vecs.push_back(v);
   endfunction

   // Probe samples of +/-3 from an open gate; env decays until it drops below 236, then
   // five samples (the crossing one plus four) stay at unity and the gain ramps 240..0.
   function automatic void gen_release(int env0, int stop_gain);
      int env = env0;
      int kb = -1;
      int zeros = 0;
      int s, g_eff, g_after;
      for (int k = 0; k < 200; k++) begin
         s = (k % 2 == 1) ? -3 : 3;
         env = env - (env >>> 4);
         if (env < 3) env = 3;
         if (kb < 0 && env < 236) kb = k;
         if (kb < 0 || k <= kb + 4) g_eff = 256;
         else g_eff = 256 - 16 * (k - kb - 4);
         if (g_eff < 0) g_eff = 0;
         if (kb < 0 || k < kb + 4) g_after = 256;
         else g_after = 256 - 16 * (k - kb - 3);
         if (g_after < 0) g_after = 0;
         if (g_eff == stop_gain) break;
         add(1'b1, s, (k % 5 == 4) ? 1 : 0, (s * g_eff) >>> 8, g_after != 0);
         if (g_eff == 0) begin
            zeros++;
            if (zeros == 3) break;
         end
      end
   endfunction

   task automatic check(string name, int act, int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run_vecs(int lo, int hi);
      for (int i = lo; i < hi; i++) begin
         @(posedge clk);
         #1;
         ng_if.en_i           = vecs[i].en;
         ng_if.sample_i       = DW'(vecs[i].s);
         ng_if.sample_valid_i = 1'b1;
         exp_q.push_back(vecs[i]);
         for (int g = 0; g < vecs[i].gap; g++) begin
            @(posedge clk);
            #1;
            ng_if.sample_valid_i = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      ng_if.sample_valid_i = 1'b0;
      repeat (4) @(posedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      ng_if.en_i = 1'b1;
      ng_if.sample_i = '0;
      ng_if.sample_valid_i = 1'b0;
      chk_en = 1'b0;
      hist = 2'b00;
      n_tests = 0;
      n_fail = 0;

      for (int i = 0; i < 20; i++) add(1'b1, 250, i % 3, 0, 1'b0);
      add(1'b1, 1000, 0, 0, 1'b1);
      add(1'b1, 1000, 0, 250, 1'b1);
      add(1'b1, 1000, 0, 500, 1'b1);
      add(1'b1, 1000, 0, 750, 1'b1);
      add(1'b1, 1000, 0, 1000, 1'b1);
      add(1'b1, 1000, 1, 1000, 1'b1);
      gen_release(1000, 128);
      add(1'b1, 400, 0, 200, 1'b1);
      add(1'b1, 400, 0, 300, 1'b1);
      add(1'b1, 400, 0, 400, 1'b1);
      gen_release(400, -1);
      add(1'b0, -8388608, 0, -8388608, 1'b1);
      add(1'b0, 8388607, 0, 8388607, 1'b1);
      add(1'b0, 0, 0, 0, 1'b1);
      add(1'b1, 0, 0, 0, 1'b1);
      add(1'b1, -3, 0, -3, 1'b1);
      add(1'b1, 12345, 0, 12345, 1'b1);
      add(1'b1, -8388608, 1, -8388608, 1'b1);
      idx_g = vecs.size();
      add(1'b1, 250, 0, 0, 1'b0);
      add(1'b1, 1000, 0, 0, 1'b1);
      add(1'b1, 1000, 0, 250, 1'b1);

      fork
         begin
            vec_t e;
            int act;
            forever begin
               @(negedge clk);
               if (chk_en) begin
                  n_tests++;
                  if (ng_if.sample_valid_o !== hist[1]) begin
                     n_fail++;
                     $display("FAIL valid_timing: got %b expected %b at %0t",
                              ng_if.sample_valid_o, hist[1], $time);
                  end
                  if (ng_if.sample_valid_o === 1'b1 && exp_q.size() > 0) begin
                     e = exp_q.pop_front();
                     act = ng_if.sample_o;
                     n_tests++;
                     if (act !== e.exp_s || ng_if.gate_open_o !== e.exp_open) begin
                        n_fail++;
                        $display("FAIL sample_out (in %0d): got %0d/open %b expected %0d/open %b at %0t",
                                 e.s, act, ng_if.gate_open_o, e.exp_s, e.exp_open, $time);
                     end
                  end
                  hist = {hist[0], ng_if.sample_valid_i};
               end
            end
         end
      join_none

      #2 rst = 1'b1;
      #1;
      check("reset_sample_o", ng_if.sample_o, 0);
      check("reset_valid_o", int'(ng_if.sample_valid_o), 0);
      check("reset_gate_open", int'(ng_if.gate_open_o), 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      chk_en = 1'b1;
      run_vecs(0, idx_g);
      chk_en = 1'b0;

      // Two strobes in flight, then an asynchronous reset between clock edges.
      @(posedge clk);
      #1;
      ng_if.en_i = 1'b1;
      ng_if.sample_i = DW'(1000);
      ng_if.sample_valid_i = 1'b1;
      @(posedge clk);
      #1 ng_if.sample_i = DW'(2000);
      @(posedge clk);
      #1 ng_if.sample_valid_i = 1'b0;
      #1;
      check("pre_reset_valid", int'(ng_if.sample_valid_o), 1);
      check("pre_reset_sample", ng_if.sample_o, 1000);
      #1 rst = 1'b1;
      #1;
      check("async_reset_sample_o", ng_if.sample_o, 0);
      check("async_reset_valid_o", int'(ng_if.sample_valid_o), 0);
      check("async_reset_gate_open", int'(ng_if.gate_open_o), 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("post_reset_no_valid", int'(ng_if.sample_valid_o), 0);
      end

      hist = 2'b00;
      chk_en = 1'b1;
      run_vecs(idx_g, vecs.size());
      chk_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
